// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizes for the asynchronous SRAM initiator and its wait-state timer.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        CLEAR  = 3'd4
    } state_e;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_WAIT_CYCLES = 2;

    // Wide enough for the largest legal wait-state setting (15).
    localparam int WAIT_CNT_W = 4;

    // Reload value for the down-counter: the timer expires on the last ACCESS cycle.
    function automatic logic [WAIT_CNT_W-1:0] wait_load(input int wait_cycles);
        return WAIT_CNT_W'(wait_cycles - 1);
    endfunction

endpackage

// File: rtl/sram_ctrl_wait_timer.sv
// Loadable down-counter that flags the final strobe-active cycle of an SRAM access.
module sram_ctrl_wait_timer
    import sram_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [WAIT_CNT_W-1:0] load_val_i,
    input  logic                  dec_i,
    output logic                  expire_o
);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Valid/ready initiator for the asynchronous single-port SRAM with programmable wait states.
// Define SRAM_CTRL_CLEAR_EN to zero-fill the whole array after every reset before accepting requests.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_address,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_ce_n,
    output logic                  sram_we_n,
    output logic                  sram_oe_n
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

    state_e                state_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  ce_n_q;
    logic                  we_n_q;
    logic                  oe_n_q;
    logic                  drive_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  req_ready_q;
    logic                  init_done_w;
    logic                  handshake;
    logic                  timer_load;
    logic                  timer_dec;
    logic                  timer_expire;

`ifdef SRAM_CTRL_CLEAR_EN
    logic                  init_done_q;
    assign init_done_w = init_done_q;
`else
    assign init_done_w = 1'b1;
`endif

    assign handshake  = req_valid && req_ready_q;
    assign timer_load = (state_q == SETUP);
    assign timer_dec  = (state_q == ACCESS);

    sram_ctrl_wait_timer u_wait_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timer_load),
        .load_val_i (WAIT_LOAD),
        .dec_i      (timer_dec),
        .expire_o   (timer_expire)
    );

    // Every pin is a flop; strobe values are chosen on the edge that enters each phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef SRAM_CTRL_CLEAR_EN
            state_q     <= CLEAR;
            init_done_q <= 1'b0;
`else
            state_q     <= IDLE;
`endif
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ce_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            drive_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        state_q     <= SETUP;
                        write_q     <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        ce_n_q      <= 1'b0;
                        oe_n_q      <= req_write;
                        drive_q     <= req_write;
                        req_ready_q <= 1'b0;
                    end else begin
                        req_ready_q <= init_done_w;
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
                    we_n_q  <= ~write_q;
                end
                ACCESS: begin
                    if (timer_expire) begin
                        state_q     <= HOLD;
                        we_n_q      <= 1'b1;
                        rsp_valid_q <= init_done_w;
                        if (!write_q) begin
                            rsp_rdata_q <= sram_data;
                        end
                    end
                end
                HOLD: begin
                    ce_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    drive_q <= 1'b0;
`ifdef SRAM_CTRL_CLEAR_EN
                    if (!init_done_q && !(&addr_q)) begin
                        state_q <= CLEAR;
                        addr_q  <= addr_q + 1'b1;
                    end else begin
                        state_q     <= IDLE;
                        init_done_q <= 1'b1;
                        req_ready_q <= 1'b1;
                    end
`else
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
`endif
                end
`ifdef SRAM_CTRL_CLEAR_EN
                CLEAR: begin
                    // Zero-fill write to addr_q, same strobe sequence as a normal write.
                    state_q <= SETUP;
                    write_q <= 1'b1;
                    wdata_q <= '0;
                    ce_n_q  <= 1'b0;
                    oe_n_q  <= 1'b1;
                    drive_q <= 1'b1;
                end
`endif
                default: begin
                    state_q     <= IDLE;
                    ce_n_q      <= 1'b1;
                    we_n_q      <= 1'b1;
                    oe_n_q      <= 1'b1;
                    drive_q     <= 1'b0;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign init_done    = init_done_w;
    assign sram_address = addr_q;
    assign sram_ce_n    = ce_n_q;
    assign sram_we_n    = we_n_q;
    assign sram_oe_n    = oe_n_q;
    assign sram_data    = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized bench for sram_ctrl: three instances (W=2, 1, 15), each with its own SRAM model.
// Expected data comes from a last-written-value array; timing from the phase rules (W+3 period).
`timescale 1ns/1ps
module tb_sram_ctrl;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic        req_valid_a [NI];
    logic        req_write_a [NI];
    logic [7:0]  req_addr_a  [NI];
    logic [15:0] req_wdata_a [NI];
    logic        req_ready_a [NI];
    logic        rsp_valid_a [NI];
    logic [15:0] rsp_rdata_a [NI];
    logic        init_done_a [NI];
    logic [7:0]  addr_a      [NI];
    logic        ce_a        [NI];
    logic        we_a        [NI];
    logic        oe_a        [NI];
    logic [15:0] bus_a       [NI];

    logic [15:0] ref_mem [NI][256];

    function automatic logic [15:0] init_pat(input int i);
        return 16'hC3A0 ^ 16'(i * 257);
    endfunction

    function automatic int wp(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int WP = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        wire [15:0] bus;
        logic [15:0] mem [256];
        logic we_prev = 1'b1;

        sram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_CYCLES(WP)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .req_valid    (req_valid_a[g]),
            .req_ready    (req_ready_a[g]),
            .req_write    (req_write_a[g]),
            .req_addr     (req_addr_a[g]),
            .req_wdata    (req_wdata_a[g]),
            .rsp_valid    (rsp_valid_a[g]),
            .rsp_rdata    (rsp_rdata_a[g]),
            .init_done    (init_done_a[g]),
            .sram_address (addr_a[g]),
            .sram_data    (bus),
            .sram_ce_n    (ce_a[g]),
            .sram_we_n    (we_a[g]),
            .sram_oe_n    (oe_a[g])
        );

        // SRAM device model: drives on read, commits a write when WE# has risen with CE# still low.
        assign bus      = (!ce_a[g] && !oe_a[g] && we_a[g]) ? mem[addr_a[g]] : 16'hzzzz;
        assign bus_a[g] = bus;

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = init_pat(i);
        end

        always @(posedge clk) begin
            if (!ce_a[g] && we_a[g] && !we_prev) mem[addr_a[g]] <= bus;
            we_prev <= we_a[g];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge of the IDLE cycle that follows HOLD.
    task automatic txn(input int g, input bit wr, input logic [7:0] a, input logic [15:0] d,
                       input bit keep, output int hs);
        int n, w, we_lo, oe_lo, both, ce_bad, adr_bad, drv_bad, rv, rv_at;
        logic [15:0] rd_before;
        string t;
        t = $sformatf("g%0d_%s%02h", g, wr ? "wr" : "rd", a);
        w = wp(g);
        rd_before = rsp_rdata_a[g];
        req_valid_a[g] = 1'b1;
        req_write_a[g] = wr;
        req_addr_a[g]  = a;
        req_wdata_a[g] = d;
        n = 0;
        while (!req_ready_a[g] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_a[g]) begin
            chk({t, "_accept_timeout"}, 0, 1);
            req_valid_a[g] = 1'b0;
            hs = -1;
            return;
        end
        @(posedge clk);
        we_lo = 0; oe_lo = 0; both = 0; ce_bad = 0; adr_bad = 0; drv_bad = 0; rv = 0; rv_at = -1;
        hs = 0;
        for (int k = 1; k <= w + 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                hs = cyc;
                if (!keep) req_valid_a[g] = 1'b0;
            end
            if (!we_a[g]) we_lo++;
            if (!oe_a[g]) oe_lo++;
            if (!we_a[g] && !oe_a[g]) both++;
            if (rsp_valid_a[g]) begin
                rv++;
                rv_at = k;
            end
            if (k <= w + 2) begin
                if (ce_a[g]) ce_bad++;
                if (addr_a[g] !== a) adr_bad++;
                if (wr && bus_a[g] !== d) drv_bad++;
            end else if (!ce_a[g]) begin
                ce_bad++;
            end
        end
        chk({t, "_we_low_cycles"}, we_lo, wr ? w : 0);
        chk({t, "_oe_low_cycles"}, oe_lo, wr ? 0 : w + 2);
        chk({t, "_we_oe_overlap"}, both, 0);
        chk({t, "_ce_window"}, ce_bad, 0);
        chk({t, "_addr_hold"}, adr_bad, 0);
        chk({t, "_rsp_valid_pos"}, rv_at, w + 2);
        chk({t, "_rsp_valid_cnt"}, rv, 1);
        if (wr) begin
            chk({t, "_bus_drive"}, drv_bad, 0);
            chk({t, "_rdata_held"}, rsp_rdata_a[g], rd_before);
            ref_mem[g][a] = d;
        end else begin
            chk({t, "_rdata"}, rsp_rdata_a[g], ref_mem[g][a]);
        end
    endtask

    task automatic b2b(input int g, input int cnt);
        int hs, prev;
        logic [7:0] a;
        prev = -1;
        for (int i = 0; i < cnt; i++) begin
            a = (i % 4 == 0 || i % 4 == 3) ? 8'h00 : 8'hFF;
            txn(g, (i % 2) == 0, a, 16'($urandom), 1'b1, hs);
            if (i > 0) chk($sformatf("g%0d_b2b_period%0d", g, i), hs - prev, wp(g) + 3);
            prev = hs;
        end
        req_valid_a[g] = 1'b0;
    endtask

    task automatic wait_init();
        int n;
        logic all;
        n = 0;
        all = 1'b0;
        while (!all && n < 10000) begin
            all = 1'b1;
            for (int g = 0; g < NI; g++) if (!init_done_a[g]) all = 1'b0;
            if (!all) begin
                @(negedge clk);
                n++;
            end
        end
        chk("init_done_all", all, 1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, n, rv;
        logic [7:0] pick [5];
        for (int g = 0; g < NI; g++) begin
            req_valid_a[g] = 1'b0;
            req_write_a[g] = 1'b0;
            req_addr_a[g]  = '0;
            req_wdata_a[g] = '0;
            for (int i = 0; i < 256; i++) begin
`ifdef SRAM_CTRL_CLEAR_EN
                ref_mem[g][i] = 16'h0000;
`else
                ref_mem[g][i] = init_pat(i);
`endif
            end
        end
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready_a[0], 0);
        chk("rst_rsp_valid", rsp_valid_a[0], 0);
        chk("rst_rsp_rdata", rsp_rdata_a[0], 0);
        chk("rst_sram_addr", addr_a[0], 0);
        chk("rst_strobes", {ce_a[0], we_a[0], oe_a[0]}, 3'b111);
`ifdef SRAM_CTRL_CLEAR_EN
        chk("rst_init_done", init_done_a[0], 0);
        reset = 1'b0;
        n = 0;
        while (!init_done_a[0] && n < 3000) begin
            @(negedge clk);
            n++;
            if (!init_done_a[0] && req_ready_a[0]) chk("clear_req_ready", req_ready_a[0], 0);
        end
        chk("clear_latency", n, (wp(0) + 3) * 256);
        wait_init();
`else
        chk("rst_init_done", init_done_a[0], 1);
        reset = 1'b0;
        @(negedge clk);
        chk("first_req_ready", req_ready_a[0], 1);
`endif

        txn(0, 1'b0, 8'h7C, 16'h0, 1'b0, hs);
        txn(0, 1'b1, 8'h05, 16'hA5A5, 1'b0, hs);
        txn(0, 1'b0, 8'h05, 16'h0, 1'b0, hs);

        b2b(0, 8);

        // Abort a write during ACCESS; the old contents must survive.
        txn(0, 1'b1, 8'h10, 16'h1234, 1'b0, hs);
        req_valid_a[0] = 1'b1;
        req_write_a[0] = 1'b1;
        req_addr_a[0]  = 8'h10;
        req_wdata_a[0] = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid_a[0] = 1'b0;
        @(negedge clk);
        chk("abort_in_access", we_a[0], 0);
        reset = 1'b1;
        #1;
        chk("abort_strobes", {ce_a[0], we_a[0], oe_a[0]}, 3'b111);
        chk("abort_rsp_valid", rsp_valid_a[0], 0);
        chk("abort_rsp_rdata", rsp_rdata_a[0], 0);
        chk("abort_req_ready", req_ready_a[0], 0);
        @(negedge clk);
        reset = 1'b0;
        rv = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid_a[0]) rv++;
        end
        chk("abort_no_rsp", rv, 0);
`ifdef SRAM_CTRL_CLEAR_EN
        for (int g = 0; g < NI; g++) for (int i = 0; i < 256; i++) ref_mem[g][i] = 16'h0000;
        wait_init();
`endif
        txn(0, 1'b0, 8'h10, 16'h0, 1'b0, hs);

        pick[0] = 8'h05; pick[1] = 8'h10; pick[2] = 8'h7C; pick[3] = 8'hFF; pick[4] = 8'h00;
        for (int g = 0; g < NI; g++) begin
            for (int i = 0; i < 12; i++) begin
                txn(g, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 4) == 0) ? 8'($urandom) : pick[$urandom_range(0, 4)],
                    16'($urandom), 1'($urandom_range(0, 1)), hs);
            end
            req_valid_a[g] = 1'b0;
            @(negedge clk);
        end

        b2b(1, 4);
        b2b(2, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Synchronous initiator for the team's asynchronous single-port SRAM (active-low chip, write and output enables, bidirectional data bus). It converts a valid/ready request port into correctly sequenced SRAM strobe cycles with programmable wait states. It also returns read data and a completion pulse. It sits between the datapath/sequencer and the external or modelled SRAM.

## Interface
- DATA_WIDTH, 16, data word width
- ADDR_WIDTH, 8, address width; the addressed depth is 2**ADDR_WIDTH
- WAIT_CYCLES, 2, number of strobe-active ACCESS cycles; legal range 1..15
- clk  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  request accepted when high together with req_valid
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  word address
- req_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  one-cycle completion pulse for reads and writes
- rsp_rdata  output  DATA_WIDTH  last read data; held between reads
- init_done  output  1  memory ready for requests
- sram_address  output  ADDR_WIDTH  SRAM address
- sram_data  inout  DATA_WIDTH  SRAM data bus
- sram_ce_n  output  1  chip enable, active low
- sram_we_n  output  1  write enable, active low
- sram_oe_n  output  1  output enable, active low

## Operation
- States: IDLE, SETUP, ACCESS, HOLD, plus CLEAR (macro only).
- req_ready = 1 only in IDLE with init_done = 1.
- On acceptance, req_write, req_addr and req_wdata are registered. The registered address drives sram_address for the whole transaction.
- Write sequence:
  - SETUP: ce_n=0, we_n=1, oe_n=1, data driven.
  - ACCESS: we_n=0, data driven.
  - HOLD: we_n=1, data still driven, ce_n=0.
- Read sequence:
  - SETUP: ce_n=0, oe_n=0, we_n=1, bus tri-stated.
  - ACCESS: same strobes.
  - HOLD: same strobes; data was captured into rsp_rdata on the clock edge ending the last ACCESS cycle.
- sram_data is driven only during write SETUP/ACCESS/HOLD. It is high-Z at all other times.
- oe_n=0 and we_n=0 are never asserted simultaneously.
- rsp_valid = 1 for exactly the HOLD cycle. rsp_rdata does not change on writes.
- Transitions:
  - IDLE→SETUP on handshake.
  - SETUP→ACCESS after one cycle.
  - ACCESS→HOLD when the wait counter reaches WAIT_CYCLES-1.
  - HOLD→IDLE after one cycle.
- Back-to-back requests are allowed. The next request is accepted in the IDLE cycle following HOLD.
- Reset asserted mid-transaction (async):
  - state→IDLE (CLEAR with macro)
  - ce_n=we_n=oe_n=1, bus high-Z
  - rsp_valid=0, rsp_rdata=0
  - the aborted transaction produces no rsp_valid.

## Timing
- Reset values:
  - req_ready=0 until the first clock with init_done=1 in IDLE.
  - rsp_valid=0, rsp_rdata=0.
  - sram_address=0.
  - ce_n=we_n=oe_n=1, bus high-Z.
  - init_done=1 without the macro, 0 with it.
- Handshake at edge T. SETUP covers T..T+1, ACCESS T+1..T+1+W, HOLD T+1+W..T+2+W, IDLE from T+2+W.
- rsp_valid is high in the cycle after edge T+1+W.
- Transaction period is WAIT_CYCLES+3 clocks per operation.
- All outputs are registered; no combinational path from request inputs to SRAM pins.

## Configuration
- SRAM_CTRL_CLEAR_EN defined:
  - After reset deasserts, CLEAR runs full write sequences of data 0 to addresses 0..2**ADDR_WIDTH-1 in ascending order.
  - Each address uses the same SETUP/ACCESS/HOLD timing, with no rsp_valid.
  - init_done rises the cycle after the last HOLD; req_ready stays 0 until then.
  - Reset during CLEAR restarts from address 0.
- Undefined: no CLEAR state; init_done constant 1; the controller is ready in the first IDLE cycle after reset.

## Structure
- Package sram_ctrl_pkg:
  - state enum (IDLE, SETUP, ACCESS, HOLD, CLEAR)
  - default width constants
  - wait-counter width constant (4 bits)
- Sub-module sram_ctrl_wait_timer:
  - loadable down-counter
  - asserts expire at terminal count
  - reset async to 0

## Test plan
- Reset, then write addr 0x05 data 0xA5A5 with W=2: we_n low exactly 2 cycles inside ce_n low; data driven from SETUP through HOLD; rsp_valid at T+3.
- Read addr 0x05 after that write: oe_n low 4 cycles (SETUP, 2 ACCESS, HOLD); bus never driven by controller; rsp_rdata=0xA5A5 with rsp_valid at T+3.
- Continuously asserted req_valid, write/read alternating to 0x00/0xFF: one accept every 5 cycles; never we_n=0 together with oe_n=0.
- Reset pulse during ACCESS of a write to 0x10: strobes high and bus high-Z immediately; no rsp_valid; a later read of 0x10 returns the prior value.
- WAIT_CYCLES=1 and WAIT_CYCLES=15: period 4 and 18 cycles respectively, with correct read data.
- With SRAM_CTRL_CLEAR_EN, ADDR_WIDTH=8: init_done rises after 256×5 cycles; a read of 0x7C then returns 0x0000.
